// File: rtl/display_pkg.sv
// Shared 7-segment definitions for the floor indicator: segment codes,
// the seg_t type and the decimal digit to segment mapping.
package display_pkg;

    typedef logic [6:0] seg_t;  // {a,b,c,d,e,f,g}, active-high

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_DASH  = 7'b0000001;
    localparam seg_t SEG_BLANK = 7'b0000000;

    function automatic seg_t digit_to_seg(input int unsigned d);
        seg_t s;
        case (d)
            0:       s = SEG_0;
            1:       s = SEG_1;
            2:       s = SEG_2;
            3:       s = SEG_3;
            4:       s = SEG_4;
            5:       s = SEG_5;
            6:       s = SEG_6;
            7:       s = SEG_7;
            8:       s = SEG_8;
            9:       s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-N counter producing a one-cycle wrap pulse on its last count,
// with a synchronous clear that holds it at zero.
module tick_divider #(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic wrap
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] count;

    assign wrap = !clear && (count == W'(N - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || wrap) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/floor_display_mux.sv
// Multiplexed decimal floor indicator with blink and out-of-range dashes.
// Build option LEADING_ZERO_BLANK_EN blanks a zero tens digit on valid floors.
module floor_display_mux
    import display_pkg::*;
#(
    parameter int FLOOR_W    = 4,
    parameter int MAX_FLOOR  = 12,
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 4,
    parameter int BLINK_DIV  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  blink,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    logic [FLOOR_W-1:0] floor_r;
    logic               blink_r;
    logic               digit_idx;
    logic               phase_off;
    logic               scan_wrap;
    logic               blink_wrap;
    logic               blink_clear;
    int unsigned        fval;
    int unsigned        tens;
    int unsigned        units;
    seg_t               digit_code;

    // Holding the blink counter cleared while blink is low means it already
    // sits at zero with phase ON on the first high cycle, so the rising edge
    // starts a full-length ON window without a separate edge detector.
    assign blink_clear = !blink_r;

    tick_divider #(.N(SCAN_DIV)) u_scan_div (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (1'b0),
        .wrap    (scan_wrap)
    );

    tick_divider #(.N(BLINK_DIV)) u_blink_div (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (blink_clear),
        .wrap    (blink_wrap)
    );

    always_comb begin
        fval       = 32'(floor_r);
        tens       = fval / 10;
        units      = fval % 10;
        digit_code = digit_to_seg(units);
        if (fval > 32'(MAX_FLOOR)) begin
            digit_code = SEG_DASH;
        end else if (digit_idx) begin
`ifdef LEADING_ZERO_BLANK_EN
            digit_code = (tens == 0) ? SEG_BLANK : digit_to_seg(tens);
`else
            digit_code = digit_to_seg(tens);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            floor_r   <= '0;
            blink_r   <= 1'b0;
            digit_idx <= 1'b0;
            phase_off <= 1'b0;
            seg       <= SEG_BLANK;
            an        <= '0;
        end else begin
            floor_r <= floor;
            blink_r <= blink;
            if (scan_wrap && NUM_DIGITS == 2) begin
                digit_idx <= !digit_idx;
            end
            if (blink_clear) begin
                phase_off <= 1'b0;
            end else if (blink_wrap) begin
                phase_off <= !phase_off;
            end
            seg <= (blink_r && phase_off) ? SEG_BLANK : digit_code;
            an  <= NUM_DIGITS'(1) << digit_idx;
        end
    end

endmodule
